// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
// Optional macro SAR_SETTLE_EN adds a SETTLE state for registered comparators.
package sar_pkg;

  localparam int DEF_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CMP
`ifdef SAR_SETTLE_EN
    , SETTLE
`endif
  } sar_state_t;

  typedef enum logic [1:0] {
    FOUND,
    UP,
    DOWN,
    FAIL
  } sar_act_t;

  // Computed wider than any supported W so lo+hi never overflows.
  function automatic logic [31:0] mid(input logic [31:0] lo, input logic [31:0] hi);
    return (lo + hi) >> 1;
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Comparator-side and control signals of sar_search, grouped with master/slave modports.
interface sar_search_if
  import sar_pkg::*;
#(
  parameter int W = DEF_W
) ();

  // start is a request sampled only while idle; done is a one-cycle completion
  // strobe with result/err valid from that cycle on; lg/eq/sm answer trial.
  logic         start;
  logic         lg;
  logic         eq;
  logic         sm;
  logic [W-1:0] trial;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;
  sar_state_t   state;

  modport master (
    input  start, lg, eq, sm,
    output trial, busy, done, result, err, state
  );

  modport slave (
    output start, lg, eq, sm,
    input  trial, busy, done, result, err, state
  );

endinterface

// File: rtl/sar_flag_chk.sv
// Decodes comparator flags against the current search window into one action.
module sar_flag_chk
  import sar_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         lg,
  input  logic         eq,
  input  logic         sm,
  input  logic [W-1:0] trial,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output sar_act_t     act
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  // A move that would empty the window means the target changed mid-search.
  always_comb begin
    act = FAIL;
    case ({lg, eq, sm})
      3'b010: act = FOUND;
      3'b100: if (trial != MAX && trial < hi) act = UP;
      3'b001: if (trial != '0 && trial > lo) act = DOWN;
      default: act = FAIL;
    endcase
  end

endmodule

// File: rtl/sar_search.sv
// Binary search over 0..2^W-1 driving a magnitude comparator's Y operand.
// Define SAR_SETTLE_EN to insert a SETTLE cycle after every trial update.
module sar_search
  import sar_pkg::*;
#(
  parameter int W = DEF_W
) (
  input logic          clk,
  input logic          rst_n,
  sar_search_if.master bus
);

  localparam int           CW   = $clog2(W + 2);
  localparam logic [W-1:0] MAX  = {W{1'b1}};
  localparam logic [CW-1:0] LAST = CW'(W);
`ifdef SAR_SETTLE_EN
  localparam sar_state_t PROBE_ST = SETTLE;
`else
  localparam sar_state_t PROBE_ST = CMP;
`endif

  sar_state_t    state, state_n;
  logic [W-1:0]  trial, trial_n, lo, lo_n, hi, hi_n, result, result_n;
  logic [CW-1:0] count, count_n;
  logic          busy, busy_n, done, done_n, err, err_n;
  sar_act_t      act, act_eff;

  sar_flag_chk #(.W(W)) u_chk (
    .lg    (bus.lg),
    .eq    (bus.eq),
    .sm    (bus.sm),
    .trial (trial),
    .lo    (lo),
    .hi    (hi),
    .act   (act)
  );

  // A further move after W+1 compares cannot be a legal search.
  always_comb begin
    act_eff = act;
    if ((act == UP || act == DOWN) && count == LAST) act_eff = FAIL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      lo     <= '0;
      hi     <= MAX;
      result <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      trial  <= trial_n;
      lo     <= lo_n;
      hi     <= hi_n;
      result <= result_n;
      count  <= count_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    trial_n  = trial;
    lo_n     = lo;
    hi_n     = hi;
    result_n = result;
    count_n  = count;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = err;
    case (state)
      IDLE: begin
        if (bus.start) begin
          lo_n    = '0;
          hi_n    = MAX;
          trial_n = MAX >> 1;
          count_n = '0;
          busy_n  = 1'b1;
          err_n   = 1'b0;
          state_n = PROBE_ST;
        end
      end
      CMP: begin
        case (act_eff)
          FOUND: begin
            result_n = trial;
            done_n   = 1'b1;
            busy_n   = 1'b0;
            state_n  = IDLE;
          end
          UP: begin
            lo_n    = trial + 1'b1;
            trial_n = W'(mid(32'(trial) + 1, 32'(hi)));
            count_n = count + 1'b1;
            state_n = PROBE_ST;
          end
          DOWN: begin
            hi_n    = trial - 1'b1;
            trial_n = W'(mid(32'(lo), 32'(trial) - 1));
            count_n = count + 1'b1;
            state_n = PROBE_ST;
          end
          default: begin
            result_n = trial;
            done_n   = 1'b1;
            busy_n   = 1'b0;
            err_n    = 1'b1;
            state_n  = IDLE;
          end
        endcase
      end
`ifdef SAR_SETTLE_EN
      SETTLE: state_n = CMP;
`endif
      default: state_n = IDLE;
    endcase
  end

  assign bus.trial  = trial;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;
  assign bus.err    = err;
  assign bus.state  = state;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural comparator, vector table, corner-case sequences.
module tb_sar_search;
  import sar_pkg::*;

  localparam int W = 4;
`ifdef SAR_SETTLE_EN
  localparam int MULT = 2;
`else
  localparam int MULT = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // behavioural comparator with an override for forced flag patterns
  logic [W-1:0] target = '0;
  logic         ovr = 1'b0;
  logic [2:0]   ovr_f = 3'b000;

  sar_search_if #(.W(W)) bus ();

  assign bus.lg = ovr ? ovr_f[2] : (target > bus.trial);
  assign bus.eq = ovr ? ovr_f[1] : (target == bus.trial);
  assign bus.sm = ovr ? ovr_f[0] : (target < bus.trial);

  sar_search #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard: every DONE consumes one expected {err, result}
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      check("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin : pop
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sb_result", 32'(bus.result), 32'(e[W-1:0]));
        check("sb_err", 32'(bus.err), 32'(e[W]));
      end
    end
  end

  // reference binary search, probes packed 4 bits each, first probe lowest
  task automatic model(input logic [W-1:0] tgt, output int n, output logic [23:0] pr);
    int lo, hi, t;
    lo = 0; hi = (1 << W) - 1; n = 0; pr = '0;
    while (n < 6) begin
      t = (lo + hi) / 2;
      pr[n*4 +: 4] = t[3:0];
      n++;
      if (t == int'(tgt)) break;
      if (int'(tgt) > t) lo = t + 1;
      else hi = t - 1;
    end
  endtask

  task automatic run_search(input logic [W-1:0] tgt, input bit sw_en, input logic [W-1:0] sw_at,
                            input logic [W-1:0] sw_tgt, input bit dup_start, input bit glitch,
                            input logic [W-1:0] exp_res, input bit exp_err, input int exp_n,
                            input logic [23:0] exp_pr, input string tag);
    logic [23:0]  got;
    logic [W-1:0] last;
    int np, busy_low, lat;
    bit switched;
    got = '0; last = '0; np = 0; busy_low = 0; lat = -1; switched = 0;
    target = tgt;
    @(negedge clk);
    bus.start = 1'b1;
    exp_q.push_back({exp_err, exp_res});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0;
        check({tag, "_err_clr"}, 32'(bus.err), 0);
      end
      if (dup_start) bus.start = (i == 1);
`ifdef SAR_SETTLE_EN
      if (glitch) begin
        ovr   = (i % 2 == 0);
        ovr_f = 3'b111;
      end
`else
      if (glitch) ovr = 1'b0;
`endif
      if (bus.done) begin
        lat = i;
        check({tag, "_busy_done"}, 32'(bus.busy), 0);
        break;
      end
      if (!bus.busy) busy_low++;
      if (np == 0 || bus.trial != last) begin
        if (np < 6) got[np*4 +: 4] = bus.trial;
        np++;
        last = bus.trial;
      end
      if (sw_en && !switched && bus.trial == sw_at) begin
        target = sw_tgt;
        switched = 1;
      end
    end
    ovr = 1'b0;
    bus.start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_n * MULT));
    check({tag, "_nprobes"}, 32'(np), 32'(exp_n));
    check({tag, "_probes"}, 32'(got), 32'(exp_pr));
    check({tag, "_busy_held"}, 32'(busy_low), 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(bus.done), 0);
  endtask

  typedef struct {
    logic [W-1:0] tgt;
    int           n;
    logic [23:0]  pr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          mn;
    logic [23:0] mp;
    logic [W-1:0] rt;

    vecs[0] = '{4'd11, 2, 24'h0000B7};
    vecs[1] = '{4'd0,  4, 24'h000137};
    vecs[2] = '{4'd15, 5, 24'h0FEDB7};
    vecs[3] = '{4'd5,  3, 24'h000537};
    vecs[4] = '{4'd8,  4, 24'h0089B7};
    vecs[5] = '{4'd7,  1, 24'h000007};

    bus.start = 1'b0;
    #2;
    check("rst_trial", 32'(bus.trial), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++)
      run_search(vecs[k].tgt, 0, '0, '0, 0, 0, vecs[k].tgt, 1'b0, vecs[k].n, vecs[k].pr, "vec");

    for (int k = 0; k < 4; k++) begin
      rt = W'($urandom_range(0, (1 << W) - 1));
      model(rt, mn, mp);
      run_search(rt, 0, '0, '0, 0, 0, rt, 1'b0, mn, mp, "rand");
    end

    // two flags high on the first compare
    ovr = 1'b1;
    ovr_f = 3'b110;
    run_search(4'd11, 0, '0, '0, 0, 0, 4'd7, 1'b1, 1, 24'h000007, "multi_flag");
    repeat (3) @(negedge clk);
    check("err_hold", 32'(bus.err), 1);
    run_search(4'd5, 0, '0, '0, 0, 0, 4'd5, 1'b0, 3, 24'h000537, "after_err");

    // target moves 3 -> 12 after the first SM, plus a START while busy
    run_search(4'd3, 1, 4'd3, 4'd12, 1, 0, 4'd6, 1'b1, 4, 24'h006537, "moved");

    // asynchronous reset mid-search
    target = 4'd15;
    @(negedge clk);
    bus.start = 1'b1;
    exp_q.push_back({1'b0, 4'd15});
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.trial == 4'd11) break;
      @(negedge clk);
    end
    check("rst_mid_reach", 32'(bus.trial), 11);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trial", 32'(bus.trial), 0);
    check("arst_result", 32'(bus.result), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_err", 32'(bus.err), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_search(4'd11, 0, '0, '0, 0, 0, 4'd11, 1'b0, 2, 24'h0000B7, "post_rst");

`ifdef SAR_SETTLE_EN
    run_search(4'd11, 0, '0, '0, 0, 1, 4'd11, 1'b0, 2, 24'h0000B7, "glitch");
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
